// File: rtl/ascon_pack.sv
// Shared Ascon types and constants.
//   type_state     : 320-bit permutation state, word 0 = x0 ... word 4 = x4
//   round_constant : constants for round indices 0..11 (p^12 starts at 0, p^6 at 6)
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [7:0] round_constant [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Request/response bundle between a permutation client and ascon_perm_engine.
//   start_i  : request a permutation (sampled only when the engine is not busy)
//   rounds_i : 0 = p^6, 1 = p^12 (sampled with start_i)
//   state_i  : input state (sampled with start_i)
//   state_o  : engine state register
//   busy_o   : permutation running
//   done_o   : one-cycle pulse, state_o holds the result
interface ascon_perm_engine_if;
  import ascon_pack::*;

  logic      start_i;
  logic      rounds_i;
  type_state state_i;
  type_state state_o;
  logic      busy_o;
  logic      done_o;

  modport master (output start_i, rounds_i, state_i, input state_o, busy_o, done_o);
  modport slave  (input start_i, rounds_i, state_i, output state_o, busy_o, done_o);

endinterface

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon permutation: one round per clock, p^6 or p^12.
//   clock_i : clock, all updates on the rising edge
//   reset_i : synchronous active-high reset
//   bus     : ascon_perm_engine_if.slave (start/rounds/state in, state/busy/done out)
module ascon_perm_engine
  import ascon_pack::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  ascon_perm_engine_if.slave  bus
);

  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_P12  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_P6   = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(11);

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  logic [1:0]       r_fsm;
  logic [1:0]       w_fsm_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  type_state        r_state;
  type_state        w_state_nxt;
  type_state        w_round_out;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full round: constant addition, column S-box (x0 is the MSB), linear diffusion.
  function automatic type_state ascon_round(input type_state s, input logic [7:0] rc);
    type_state  a;
    type_state  b;
    type_state  l;
    logic [4:0] col;
    logic [4:0] sb;
    a = s;
    a[2][7:0] = a[2][7:0] ^ rc;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      col = {a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]};
      sb  = SBOX[col];
      b[0][i] = sb[4];
      b[1][i] = sb[3];
      b[2][i] = sb[2];
      b[3][i] = sb[1];
      b[4][i] = sb[0];
    end
    l[0] = b[0] ^ ror64(b[0], 19) ^ ror64(b[0], 28);
    l[1] = b[1] ^ ror64(b[1], 61) ^ ror64(b[1], 39);
    l[2] = b[2] ^ ror64(b[2], 1)  ^ ror64(b[2], 6);
    l[3] = b[3] ^ ror64(b[3], 10) ^ ror64(b[3], 17);
    l[4] = b[4] ^ ror64(b[4], 7)  ^ ror64(b[4], 41);
    return l;
  endfunction

  always_comb begin
    w_round_out = ascon_round(r_state, round_constant[r_idx]);
  end

  // Next-state logic; a start in DONE is a back-to-back run.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    case (r_fsm)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          w_state_nxt = bus.state_i;
          w_idx_nxt   = bus.rounds_i ? IDX_P12 : IDX_P6;
          w_fsm_nxt   = ST_RUN;
        end else begin
          w_fsm_nxt   = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_state_nxt = w_round_out;
        if (r_idx == IDX_LAST) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
        w_idx_nxt = IDX_P12;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm   <= ST_IDLE;
      r_idx   <= IDX_P12;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign bus.state_o = r_state;
  assign bus.busy_o  = (r_fsm == ST_RUN);
  assign bus.done_o  = (r_fsm == ST_DONE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
module tb_ascon_perm_engine;
  import ascon_pack::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ascon_perm_engine_if bus_if ();

  ascon_perm_engine dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SBOX_TAB [32] = '{
    'h04, 'h0B, 'h1F, 'h14, 'h1A, 'h15, 'h09, 'h02,
    'h1B, 'h05, 'h08, 'h12, 'h1D, 'h03, 'h06, 'h1C,
    'h1E, 'h13, 'h07, 'h0E, 'h00, 'h0D, 'h11, 'h18,
    'h10, 'h0C, 'h01, 'h19, 'h16, 'h0A, 'h0F, 'h17
  };
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // Reference: bit-array model; constants derived as ((15-r)<<4)|r.
  function automatic type_state model_perm(input logic r12, input type_state s_in);
    bit [63:0] x [5];
    bit [63:0] y [5];
    int        v;
    int        first;
    type_state res;
    for (int w = 0; w < 5; w++) x[w] = s_in[w];
    first = r12 ? 0 : 6;
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int c = 0; c < 64; c++) begin
        v = 0;
        for (int w = 0; w < 5; w++) v = v * 2 + int'(x[w][c]);
        v = SBOX_TAB[v];
        for (int w = 0; w < 5; w++) y[w][c] = v[4 - w];
      end
      for (int w = 0; w < 5; w++)
        for (int c = 0; c < 64; c++)
          x[w][c] = y[w][c] ^ y[w][(c + ROT_A[w]) % 64] ^ y[w][(c + ROT_B[w]) % 64];
    end
    for (int w = 0; w < 5; w++) res[w] = x[w];
    return res;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic void chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Inputs already driven with start_i=1; covers E0 through the done cycle.
  task automatic run_check(input logic r12, input type_state exp, input string nm, input bit noise);
    int n;
    n = r12 ? 12 : 6;
    @(posedge clk); #1;
    bus_if.start_i = noise ? 1'($urandom()) : 1'b0;
    if (noise) begin
      bus_if.state_i  = rand_state();
      bus_if.rounds_i = 1'($urandom());
    end
    chk({nm, " busy/done E0"}, {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b10);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        chk({nm, " busy/done run"}, {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b10);
        if (noise) begin
          bus_if.start_i  = 1'($urandom());
          bus_if.state_i  = rand_state();
          bus_if.rounds_i = 1'($urandom());
        end
      end else begin
        chk({nm, " busy/done end"}, {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b01);
        chk({nm, " result"}, bus_if.state_o, exp);
      end
    end
  endtask

  task automatic idle_check(input type_state hold, input string nm);
    @(posedge clk); #1;
    chk({nm, " idle busy/done"}, {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b00);
    chk({nm, " idle hold"}, bus_if.state_o, hold);
  endtask

  typedef struct {
    string     name;
    logic      r12;
    type_state st;
    type_state exp;
  } vec_t;

  vec_t      vecs [8];
  type_state s_a;
  type_state s_b;
  type_state e_a;
  type_state e_b;
  logic      r_a;
  logic      r_b;
  bit        b2b;
  bit        quiet;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.start_i  = 1'b0;
    bus_if.rounds_i = 1'b0;
    bus_if.state_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", bus_if.state_o, 320'd0);
    chk("reset busy/done", {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b00);

    vecs[0] = '{"p12 zero", 1'b1, '0, '0};
    vecs[1] = '{"p6 iv", 1'b0, {256'd0, 64'h80400C0600000000}, '0};
    vecs[2] = '{"p12 ones", 1'b1, '1, '0};
    vecs[3] = '{"p6 ones", 1'b0, '1, '0};
    vecs[4] = '{"p6 zero", 1'b0, '0, '0};
    vecs[5] = '{"p12 x4 lsb", 1'b1, {64'd1, 256'd0}, '0};
    vecs[6] = '{"p12 alt", 1'b1, {5{64'hA5A5_5A5A_0F0F_F0F0}}, '0};
    vecs[7] = '{"p12 iv", 1'b1, {256'd0, 64'h80400C0600000000}, '0};
    for (int i = 0; i < 8; i++) vecs[i].exp = model_perm(vecs[i].r12, vecs[i].st);

    // First start straight after reset release.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_if.start_i  = 1'b1;
      bus_if.rounds_i = vecs[i].r12;
      bus_if.state_i  = vecs[i].st;
      run_check(vecs[i].r12, vecs[i].exp, vecs[i].name, 1'b0);
      bus_if.start_i = 1'b0;
      idle_check(vecs[i].exp, vecs[i].name);
    end

    // start held high, state_i churned mid-run, then back-to-back from DONE.
    s_a = rand_state();
    s_b = rand_state();
    bus_if.start_i = 1'b1; bus_if.rounds_i = 1'b1; bus_if.state_i = s_a;
    run_check(1'b1, model_perm(1'b1, s_a), "held start", 1'b1);
    bus_if.start_i = 1'b1; bus_if.rounds_i = 1'b1; bus_if.state_i = s_b;
    run_check(1'b1, model_perm(1'b1, s_b), "b2b", 1'b0);
    bus_if.start_i = 1'b0;
    idle_check(model_perm(1'b1, s_b), "b2b");

    // Reset after five rounds of p^12 aborts the run.
    bus_if.start_i = 1'b1; bus_if.rounds_i = 1'b1; bus_if.state_i = s_a;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort state", bus_if.state_o, 320'd0);
    chk("abort busy/done", {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b00);
    quiet = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      if (bus_if.done_o !== 1'b0 || bus_if.busy_o !== 1'b0) quiet = 1'b0;
    end
    chk("abort no done", {319'd0, quiet}, 320'd1);
    bus_if.start_i = 1'b1; bus_if.rounds_i = 1'b0; bus_if.state_i = s_b;
    run_check(1'b0, model_perm(1'b0, s_b), "after abort", 1'b0);

    // Reset in DONE: result cleared, no further done.
    rst = 1'b1;
    bus_if.start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst done state", bus_if.state_o, 320'd0);
    chk("rst done busy/done", {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b00);

    // Reset in IDLE overrides a start request.
    bus_if.start_i = 1'b1; bus_if.state_i = s_a;
    @(posedge clk); #1;
    chk("rst idle start", {318'd0, bus_if.busy_o, bus_if.done_o}, 320'b00);
    chk("rst idle state", bus_if.state_o, 320'd0);
    rst = 1'b0;
    bus_if.start_i = 1'b0;
    @(posedge clk); #1;

    // Random regression with random back-to-back chaining.
    r_a = 1'($urandom());
    s_a = rand_state();
    bus_if.start_i = 1'b1; bus_if.rounds_i = r_a; bus_if.state_i = s_a;
    for (int i = 0; i < 1000; i++) begin
      e_a = model_perm(r_a, s_a);
      run_check(r_a, e_a, "random", 1'b1);
      r_b = 1'($urandom());
      s_b = rand_state();
      b2b = 1'($urandom());
      if (!b2b || i == 999) begin
        bus_if.start_i = 1'b0;
        idle_check(e_a, "random");
      end
      bus_if.start_i  = (i != 999);
      bus_if.rounds_i = r_b;
      bus_if.state_i  = s_b;
      r_a = r_b;
      s_a = s_b;
    end
    bus_if.start_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 SHALL import ascon_pack and use type_state for state ports (word 0 = x0 ... word 4 = x4) and round_constant[0:11] for constants.
REQ-002 clock_i  in  1  single clock; all state updates on rising edge.
REQ-003 reset_i  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  request to permute state_i; sampled only when not busy.
REQ-005 rounds_i  in  1  round-count select: 0 = p^6, 1 = p^12; sampled with start_i.
REQ-006 state_i  in  320 (type_state)  input state; sampled with start_i.
REQ-007 state_o  out  320 (type_state)  internal state register, always driven directly.
REQ-008 busy_o  out  1  high while a permutation is loading or running.
REQ-009 done_o  out  1  one-cycle pulse marking state_o valid with the result.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE with a 4-bit round index register.
REQ-011 IDLE or DONE with start_i=1: SHALL load state_i into the state register, load the round index with 0 (rounds_i=1) or 6 (rounds_i=0), go to RUN; no round is applied on this edge.
REQ-012 IDLE with start_i=0: SHALL hold state and stay IDLE; DONE with start_i=0: SHALL go to IDLE and hold state.
REQ-013 RUN: each edge SHALL apply exactly one round using round_constant[index], then increment the index.
REQ-014 RUN with index=11: SHALL apply the final round and go to DONE.
REQ-015 Round = constant addition (x2[7:0] ^= rc), then substitution layer, then linear layer, all combinational within one cycle.
REQ-016 Substitution SHALL apply the Ascon 5-bit S-box to each of the 64 bit columns, x0 as MSB; table 0..31 = 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17 (hex).
REQ-017 Linear layer, rotations right: x0^=ROR19^ROR28; x1^=ROR61^ROR39; x2^=ROR1^ROR6; x3^=ROR10^ROR17; x4^=ROR7^ROR41, each rotation of the pre-layer word.
REQ-018 Latency: start accepted at edge E0 -> rounds at E1..EN (N=12 or 6) -> done_o=1 in the cycle after EN, state_o = result.
REQ-019 busy_o SHALL be 1 in RUN only (the cycles after E0 through EN); 0 in IDLE and DONE.
REQ-020 done_o SHALL be 1 only in DONE, for exactly one cycle per permutation.
REQ-021 start_i, rounds_i, state_i SHALL be ignored while in RUN; state_i changes mid-run SHALL not affect the result.
REQ-022 start_i in DONE SHALL be accepted (back-to-back); done_o still pulses that cycle with the previous result.
REQ-023 state_o SHALL hold the last result in IDLE until the next accepted start.
REQ-024 Round index SHALL never exceed 11; no wrap-around path exists.

Reset
REQ-025 reset_i=1 at an edge SHALL force IDLE, index=0, state register=0, busy_o=0, done_o=0, overriding start_i.
REQ-026 reset_i asserted mid-RUN SHALL abort the permutation; no done_o pulse SHALL follow.
REQ-027 First start SHALL be accepted on the first edge after reset_i deasserts.

Verification
REQ-028 Reset then start_i=1, rounds_i=1, state_i=0 -> busy_o high 12 cycles, done_o pulse 13 cycles after E0, state_o equals the golden software p^12 of all-zero state.
REQ-029 rounds_i=0, state_i = {80400C0600000000, 0, 0, 0, 0} -> done_o 7 cycles after E0, state_o equals golden p^6 (constants B4? no: 96,87,78,69,5A,4B applied in order).
REQ-030 start_i held high and state_i toggled during RUN -> single done_o per run, result unaffected; start_i=1 in DONE -> new run starts, next done_o 13 cycles later.
REQ-031 reset_i pulsed at round 5 of p^12 -> next cycle state_o=0, busy_o=0, no done_o; new start completes normally.
REQ-032 Random 1000-run regression, random rounds_i and state_i, compared against golden model; coverage of both round counts, back-to-back starts, reset in every FSM state.
